data_mem_unit: RTL and testbench

//  Data-memory subsystem directly downstream of the pipeline's memory stage. Serves the

---
 rtl/data_mem_unit.sv | 132 +++++++++++++
 tb/tb_data_mem_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-memory subsystem behind the memory stage: byte/half/word RAM with load extension,
// plus a 16-byte MMIO window (tohost halt register, console TX FIFO, status).
module data_mem_unit #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmemAddr,
   input  logic [31:0] dmemWdata,
   input  logic [2:0]  dmemSize,
   input  logic        dmemWen,
   output logic [31:0] dmemRdata,
   output logic        txValid,
   output logic [7:0]  txData,
   input  logic        txReady,
   output logic        tohostValid,
   output logic [31:0] tohostData,
   output logic        misalignFault,
   output logic [31:0] faultAddr,
   output logic        txOverflow
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [31:0]   mem  [DEPTH_WORDS];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [PW:0]   count;

   logic          isByte, isHalf, isWord, isUns, aligned, isMmio;
   logic          empty, full, push, pop, doPush, ramWe, thWr;
   logic [1:0]    off;
   logic [AW-1:0] wordIdx;
   logic [31:0]   mmioWord, rawWord, wrep;
   logic [7:0]    byteSel;
   logic [15:0]   halfSel;
   logic [3:0]    be;

   // Size decode: 011/110/111 fall into the word case.
   always_comb begin
      isByte  = (dmemSize == 3'b000) || (dmemSize == 3'b100);
      isHalf  = (dmemSize == 3'b001) || (dmemSize == 3'b101);
      isWord  = !isByte && !isHalf;
      isUns   = dmemSize[2];
      aligned = isByte || (isHalf && !dmemAddr[0]) || (isWord && (dmemAddr[1:0] == 2'b00));
      isMmio  = (dmemAddr[31:4] == MMIO_BASE[31:4]);
      off     = dmemAddr[3:2];
      wordIdx = dmemAddr[AW+1:2];
      empty   = (count == '0);
      full    = (count == (PW+1)'(FIFO_DEPTH));
   end

   // Read path: pick the source word, then lane-extract and extend.
   always_comb begin
      mmioWord = 32'h0;
      case (off)
         2'd0:    mmioWord = tohostData;
         2'd2:    mmioWord = {24'h0, 5'(count), 1'b0, full, empty};
         default: mmioWord = 32'h0;
      endcase
      rawWord = isMmio ? mmioWord : mem[wordIdx];
      byteSel = rawWord[{dmemAddr[1:0], 3'b000} +: 8];
      halfSel = dmemAddr[1] ? rawWord[31:16] : rawWord[15:0];
      if (!aligned)    dmemRdata = 32'h0;
      else if (isByte) dmemRdata = {{24{!isUns && byteSel[7]}}, byteSel};
      else if (isHalf) dmemRdata = {{16{!isUns && halfSel[15]}}, halfSel};
      else             dmemRdata = rawWord;
   end

   // Store decode; only aligned stores have any effect besides the fault flag.
   always_comb begin
      be   = 4'b1111;
      wrep = dmemWdata;
      if (isByte) begin
         be   = 4'b0001 << dmemAddr[1:0];
         wrep = {4{dmemWdata[7:0]}};
      end else if (isHalf) begin
         be   = dmemAddr[1] ? 4'b1100 : 4'b0011;
         wrep = {2{dmemWdata[15:0]}};
      end
      ramWe  = dmemWen && aligned && !isMmio;
      thWr   = dmemWen && aligned && isMmio && (off == 2'd0);
      push   = dmemWen && aligned && isMmio && (off == 2'd1);
      pop    = !empty && txReady;
      doPush = push && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (!rst && ramWe)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[wordIdx][8*i +: 8] <= wrep[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst && doPush) fifo[wrPtr] <= dmemWdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr         <= '0;
         wrPtr         <= '0;
         count         <= '0;
         tohostValid   <= 1'b0;
         tohostData    <= 32'h0;
         misalignFault <= 1'b0;
         faultAddr     <= 32'h0;
         txOverflow    <= 1'b0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (pop)    rdPtr <= rdPtr + 1'b1;
         case ({doPush, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop) txOverflow <= 1'b1;
         if (thWr && !tohostValid) begin
            tohostValid <= 1'b1;
            tohostData  <= dmemWdata;
         end
         if (dmemWen && !aligned && !misalignFault) begin
            misalignFault <= 1'b1;
            faultAddr     <= dmemAddr;
         end
      end
   end

   assign txValid = !empty;
   assign txData  = empty ? 8'h0 : fifo[rdPtr];
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, hand-written FIFO/reset sequences,
// then randomized traffic checked against a byte-array / queue reference model.
module tb_data_mem_unit;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          FD    = 8;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] dmemAddr = '0, dmemWdata = '0;
   logic [2:0]  dmemSize = 3'b010;
   logic        dmemWen = 1'b0, txReady = 1'b0;
   logic [31:0] dmemRdata, tohostData, faultAddr;
   logic        txValid, tohostValid, misalignFault, txOverflow;
   logic [7:0]  txData;

   data_mem_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize),
      .dmemWen(dmemWen), .dmemRdata(dmemRdata), .txValid(txValid), .txData(txData),
      .txReady(txReady), .tohostValid(tohostValid), .tohostData(tohostData),
      .misalignFault(misalignFault), .faultAddr(faultAddr), .txOverflow(txOverflow));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   logic [31:0] lastR;

   // Reference model: byte-addressed RAM, byte queue, plain flag variables.
   bit [7:0]    mb [DEPTH*4];
   logic [7:0]  q [$];
   bit          thv, flt, ovf;
   logic [31:0] thd, fad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [2:0] s);
      if (s == 3'd0 || s == 3'd4) return 1;
      if (s == 3'd1 || s == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] mRead(input logic [31:0] a, input logic [2:0] s);
      int n = nbytes(s);
      logic [31:0] v = 0;
      if (a % n != 0) return 0;
      if (a[31:4] == BASE[31:4]) begin
         logic [31:0] w = 0;
         if (a[3:2] == 2'd0) w = thd;
         if (a[3:2] == 2'd2) w = (q.size() * 8) + ((q.size() == FD) ? 2 : 0) + ((q.size() == 0) ? 1 : 0);
         v = w >> (8 * (a % 4));
      end else begin
         int ba = int'(a % (DEPTH * 4));
         for (int i = 0; i < n; i++) v = v + (32'(mb[ba+i]) << (8 * i));
      end
      if (n == 1) begin v = v & 32'hFF;   if (!s[2] && v[7])  v = v | 32'hFFFF_FF00; end
      if (n == 2) begin v = v & 32'hFFFF; if (!s[2] && v[15]) v = v | 32'hFFFF_0000; end
      return v;
   endfunction

   task automatic mStep(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s,
                        input bit wen, input bit rdy, input bit r);
      int  n = nbytes(s);
      bit  doPop, doPush = 0;
      if (r) begin
         q.delete(); thv = 0; thd = 0; flt = 0; fad = 0; ovf = 0;
         return;
      end
      doPop = (q.size() > 0) && rdy;
      if (wen) begin
         if (a % n != 0) begin
            if (!flt) begin flt = 1; fad = a; end
         end else if (a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd0 && !thv) begin thv = 1; thd = wd; end
            if (a[3:2] == 2'd1) doPush = 1;
         end else begin
            int ba = int'(a % (DEPTH * 4));
            for (int i = 0; i < n; i++) mb[ba+i] = wd[8*i +: 8];
         end
      end
      if (doPop) void'(q.pop_front());
      if (doPush) begin
         if (q.size() < FD) q.push_back(wd[7:0]);
         else ovf = 1;
      end
   endtask

   task automatic checkAll();
      chk("txValid", 32'(txValid), 32'(q.size() != 0));
      chk("txData", 32'(txData), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      chk("tohostValid", 32'(tohostValid), 32'(thv));
      chk("tohostData", tohostData, thd);
      chk("misalignFault", 32'(misalignFault), 32'(flt));
      chk("faultAddr", faultAddr, fad);
      chk("txOverflow", 32'(txOverflow), 32'(ovf));
   endtask

   // One clock: drive, compare at negedge against model, advance model at posedge.
   task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s,
                      input bit wen, input bit rdy, input bit r, input bit cr);
      dmemAddr = a; dmemWdata = wd; dmemSize = s; dmemWen = wen; txReady = rdy; rst = r;
      @(negedge clk);
      lastR = dmemRdata;
      if (cr) chk("dmemRdata", dmemRdata, mRead(a, s));
      checkAll();
      @(posedge clk);
      mStep(a, wd, s, wen, rdy, r);
      #1;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      bit          wen;
      logic [31:0] expR;
   } vec_t;

   localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2, BU = 3'd4;

   initial begin
      vec_t vt [$];
      vt = '{
         '{32'h100,      32'h1234_5678, W,  1, 32'h0},
         '{32'h103,      32'h0,         B,  0, 32'h12},
         '{32'h103,      32'h0,         BU, 0, 32'h12},
         '{32'h102,      32'h0,         H,  0, 32'h1234},
         '{32'h101,      32'hFF,        B,  1, 32'h56},
         '{32'h101,      32'h0,         B,  0, 32'hFFFF_FFFF},
         '{32'h101,      32'h0,         BU, 0, 32'hFF},
         '{32'h100,      32'h0,         W,  0, 32'h1234_FF78},
         '{32'h101,      32'hBEEF,      H,  1, 32'h0},
         '{32'h100,      32'h0,         W,  0, 32'h1234_FF78},
         '{32'h203,      32'hDEAD,      W,  1, 32'h0},
         '{32'h102,      32'h0,         W,  0, 32'h0},
         '{BASE,         32'h1,         W,  1, 32'h0},
         '{BASE,         32'h5,         W,  1, 32'h1},
         '{BASE,         32'h0,         W,  0, 32'h1},
         '{BASE + 32'hC, 32'h0,         W,  0, 32'h0},
         '{BASE + 32'h4, 32'h0,         W,  0, 32'h0}
      };

      // Reset and check the cleared state.
      repeat (2) @(posedge clk);
      mStep(0, 0, W, 0, 0, 1);
      #1;
      checkAll();
      rst = 1'b0;

      // Zero the RAM region the bench reads from so model and RAM agree.
      for (int i = 0; i < 64; i++) cyc(32'(i * 4), 32'h0, W, 1, 0, 0, 0);

      foreach (vt[i]) begin
         cyc(vt[i].addr, vt[i].wdata, vt[i].size, vt[i].wen, 0, 0, 1);
         chk($sformatf("vec%0d", i), lastR, vt[i].expR);
      end
      chk("faultAddrKept", faultAddr, 32'h101);
      chk("faultSet", 32'(misalignFault), 32'h1);
      chk("tohostFirst", tohostData, 32'h1);

      // Console FIFO: two pushes, status, then drain.
      cyc(BASE + 4, 32'h41, B, 1, 0, 0, 1);
      chk("txValidAfterPush", 32'(txValid), 32'h1);
      chk("txHeadA", 32'(txData), 32'h41);
      cyc(BASE + 4, 32'h42, B, 1, 0, 0, 1);
      cyc(BASE + 8, 32'h0, W, 0, 0, 0, 1);
      chk("status2", lastR, 32'h10);
      cyc(32'h100, 32'h0, W, 0, 1, 0, 1);
      chk("txHeadB", 32'(txData), 32'h42);
      cyc(32'h100, 32'h0, W, 0, 1, 0, 1);
      chk("txDrained", 32'(txValid), 32'h0);

      // Overflow: nine pushes into eight entries, then push+pop while full.
      for (int i = 0; i < 9; i++) cyc(BASE + 4, 32'(8'h30 + i), B, 1, 0, 0, 1);
      chk("overflowSet", 32'(txOverflow), 32'h1);
      cyc(BASE + 8, 32'h0, W, 0, 0, 0, 1);
      chk("statusFull", lastR, 32'h42);
      cyc(BASE + 4, 32'h99, B, 1, 1, 0, 1);
      cyc(BASE + 8, 32'h0, W, 0, 0, 0, 1);
      chk("statusFullKept", lastR, 32'h42);
      chk("headAfterSwap", 32'(txData), 32'h31);

      // Reset mid-stream with a pending push and handshake.
      for (int i = 0; i < 5; i++) cyc(32'h100, 32'h0, W, 0, 1, 0, 1);
      cyc(BASE + 4, 32'h77, B, 1, 1, 1, 1);
      chk("rstTxValid", 32'(txValid), 32'h0);
      chk("rstOverflow", 32'(txOverflow), 32'h0);
      chk("rstFault", 32'(misalignFault), 32'h0);
      chk("rstTohost", 32'(tohostValid), 32'h0);
      cyc(32'h100, 32'h0, W, 0, 0, 0, 1);
      chk("ramKeptOverRst", lastR, 32'h1234_FF78);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, wd;
         logic [2:0]  s;
         wd = $urandom;
         s  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 7)
            a = ($urandom & 32'h7FFF_C000) | 32'($urandom_range(0, 255));
         else
            a = BASE | 32'($urandom_range(0, 3) << 2);
         cyc(a, wd, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 199) == 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
